// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: widths, the $zero
// register and the fixed writeback requester slots.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    // Width of an index that can name any of n requesters (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a search that starts at an internal
// pointer and wraps; the pointer moves past the winner whenever advance is high.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    import regfile_pkg::*;

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick;
    logic             found;

    always_comb begin
        grant = '0;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                pick  = IDX_W'((int'(ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback requesters and
// tracks pending writes in a busy scoreboard. Optional: REGFILE_WRITE_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int REG_AW  = regfile_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      alloc_valid,
    input  logic [REG_AW-1:0]         alloc_reg,
    input  logic [REG_AW-1:0]         read_register_1,
    input  logic [REG_AW-1:0]         read_register_2,
    output logic                      busy_1,
    output logic                      busy_2,
`ifdef REGFILE_WRITE_BYPASS_EN
    output logic                      fwd_valid_1,
    output logic                      fwd_valid_2,
    output logic [DATA_W-1:0]         fwd_data_1,
    output logic [DATA_W-1:0]         fwd_data_2,
`endif
    output logic                      regwrite,
    output logic [REG_AW-1:0]         write_register,
    output logic [DATA_W-1:0]         write_data
);
    import regfile_pkg::*;

    localparam int NREG = 1 << REG_AW;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] gnt;
    logic               any_gnt;
    logic [REG_AW-1:0]  g_reg;
    logic [DATA_W-1:0]  g_data;
    logic               g_nonzero;
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_next;
    logic               hit_1;
    logic               hit_2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (any_gnt),
        .grant   (grant)
    );

    // Grants are masked during reset so no requester sees a handshake that
    // the reset is about to discard.
    assign gnt       = rst_n ? grant : '0;
    assign any_gnt   = |gnt;
    assign req_ready = gnt;

    // The grant is one-hot, so OR-ing the masked lanes selects the winner.
    always_comb begin
        g_reg  = '0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                g_reg  = g_reg  | req_reg[i*REG_AW +: REG_AW];
                g_data = g_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign g_nonzero = (g_reg != REG_AW'(REG_ZERO));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            regwrite <= any_gnt && g_nonzero;
            if (any_gnt) begin
                write_register <= g_reg;
                write_data     <= g_data;
            end
        end
    end

    // Clear first, then set, so an alloc on the register being written back wins.
    always_comb begin
        busy_next = busy;
        if (any_gnt) begin
            busy_next[g_reg] = 1'b0;
        end
        if (alloc_valid) begin
            busy_next[alloc_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: the scoreboard is plain flops, not a RAM, so it is reset as a whole;
    // decode must never see stale busy bits after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    assign hit_1       = any_gnt && g_nonzero && (g_reg == read_register_1);
    assign hit_2       = any_gnt && g_nonzero && (g_reg == read_register_2);
    assign fwd_valid_1 = hit_1;
    assign fwd_valid_2 = hit_2;
    assign fwd_data_1  = g_data;
    assign fwd_data_2  = g_data;
`else
    assign hit_1 = 1'b0;
    assign hit_2 = 1'b0;
`endif

    assign busy_1 = busy[read_register_1] && !hit_1;
    assign busy_2 = busy[read_register_2] && !hit_2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (3 requesters).
// Covers the bypass outputs when REGFILE_WRITE_BYPASS_EN is defined.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int NR = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NR-1:0]         req_valid;
    logic [NR*REG_AW-1:0]  req_reg;
    logic [NR*DATA_W-1:0]  req_data;
    logic [NR-1:0]         req_ready;
    logic                  alloc_valid;
    logic [REG_AW-1:0]     alloc_reg;
    logic [REG_AW-1:0]     read_register_1;
    logic [REG_AW-1:0]     read_register_2;
    logic                  busy_1;
    logic                  busy_2;
    logic                  regwrite;
    logic [REG_AW-1:0]     write_register;
    logic [DATA_W-1:0]     write_data;
`ifdef REGFILE_WRITE_BYPASS_EN
    logic                  fwd_valid_1;
    logic                  fwd_valid_2;
    logic [DATA_W-1:0]     fwd_data_1;
    logic [DATA_W-1:0]     fwd_data_2;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    regfile_write_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_reg         (req_reg),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .alloc_valid     (alloc_valid),
        .alloc_reg       (alloc_reg),
        .read_register_1 (read_register_1),
        .read_register_2 (read_register_2),
        .busy_1          (busy_1),
        .busy_2          (busy_2),
`ifdef REGFILE_WRITE_BYPASS_EN
        .fwd_valid_1     (fwd_valid_1),
        .fwd_valid_2     (fwd_valid_2),
        .fwd_data_1      (fwd_data_1),
        .fwd_data_2      (fwd_data_2),
`endif
        .regwrite        (regwrite),
        .write_register  (write_register),
        .write_data      (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
        req_reg[i*REG_AW +: REG_AW]  = r;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    logic [NR-1:0]     rr_exp   [6];
    logic [DATA_W-1:0] data_exp [6];

    initial begin
        rst_n           = 1'b0;
        req_valid       = 3'b111;
        req_reg         = '0;
        req_data        = '0;
        alloc_valid     = 1'b0;
        alloc_reg       = '0;
        read_register_1 = 5'd9;
        read_register_2 = 5'd9;

        // Reset: ready masked, outputs and scoreboard cleared.
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        step();
        step();
        check("rst_regwrite", 32'(regwrite), 32'h0);
        check("rst_wreg", 32'(write_register), 32'h0);
        check("rst_wdata", write_data, 32'h0);
        check("rst_busy_1", 32'(busy_1), 32'h0);

        // Single write from the ALU slot.
        rst_n     = 1'b1;
        req_valid = 3'b001;
        set_req(REQ_ALU, 5'd8, 32'hDEADBEEF);
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b000;
        check("single_regwrite", 32'(regwrite), 32'h1);
        check("single_wreg", 32'(write_register), 32'd8);
        check("single_wdata", write_data, 32'hDEADBEEF);

        // Pointer is at 1; a lone request on slot 2 still wins and returns p to 0.
        req_valid = 3'b100;
        set_req(REQ_MULDIV, 5'd3, 32'h33);
        #1;
        check("wrap_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 3'b000;
        check("wrap_wreg", 32'(write_register), 32'd3);
        step();
        check("idle_regwrite", 32'(regwrite), 32'h0);
        check("idle_hold_wreg", 32'(write_register), 32'd3);
        check("idle_hold_wdata", write_data, 32'h33);

        // Round-robin fairness with all three requesting.
        set_req(REQ_ALU,    5'd10, 32'h000000A0);
        set_req(REQ_LOAD,   5'd11, 32'h000000B1);
        set_req(REQ_MULDIV, 5'd12, 32'h000000C2);
        rr_exp   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        data_exp = '{32'hA0, 32'hB1, 32'hC2, 32'hA0, 32'hB1, 32'hC2};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(rr_exp[k]));
            step();
            check($sformatf("rr_wdata_%0d", k), write_data, data_exp[k]);
        end
        req_valid = 3'b000;

        // $zero: handshake completes but no write; alloc of $zero ignored.
        set_req(REQ_ALU, 5'd0, 32'h1234);
        req_valid       = 3'b001;
        alloc_valid     = 1'b1;
        alloc_reg       = 5'd0;
        read_register_1 = 5'd0;
        #1;
        check("zero_ready", 32'(req_ready), 32'h1);
        step();
        req_valid   = 3'b000;
        alloc_valid = 1'b0;
        #1;
        check("zero_regwrite", 32'(regwrite), 32'h0);
        check("zero_busy", 32'(busy_1), 32'h0);

        // Scoreboard: alloc reg 9, then a write from slot 1 (pointer is 1) clears it.
        read_register_1 = 5'd9;
        read_register_2 = 5'd9;
        alloc_valid     = 1'b1;
        alloc_reg       = 5'd9;
        #1;
        check("alloc_not_yet", 32'(busy_1), 32'h0);
        step();
        alloc_valid = 1'b0;
        #1;
        check("alloc_busy_1", 32'(busy_1), 32'h1);
        check("alloc_busy_2", 32'(busy_2), 32'h1);
        set_req(REQ_LOAD, 5'd9, 32'h99);
        req_valid = 3'b010;
        #1;
        check("sb_ready", 32'(req_ready), 32'h2);
`ifdef REGFILE_WRITE_BYPASS_EN
        check("sb_busy_fwd", 32'(busy_1), 32'h0);
        check("sb_fwd_valid_1", 32'(fwd_valid_1), 32'h1);
        check("sb_fwd_data_1", fwd_data_1, 32'h99);
`else
        check("sb_busy_during_grant", 32'(busy_1), 32'h1);
`endif
        step();
        req_valid = 3'b000;
        #1;
        check("sb_cleared", 32'(busy_1), 32'h0);
        check("sb_wreg", 32'(write_register), 32'd9);

        // Alloc and clear of reg 9 in the same cycle: alloc wins.
        alloc_valid = 1'b1;
        alloc_reg   = 5'd9;
        step();
        set_req(REQ_MULDIV, 5'd9, 32'h77);
        req_valid = 3'b100;
        #1;
        check("same_ready", 32'(req_ready), 32'h4);
        step();
        req_valid   = 3'b000;
        alloc_valid = 1'b0;
        #1;
        check("same_busy", 32'(busy_1), 32'h1);
        check("same_regwrite", 32'(regwrite), 32'h1);
        check("same_wdata", write_data, 32'h77);

        // Move the pointer to 1, then reset while all three request.
        set_req(REQ_ALU,  5'd4, 32'h44);
        set_req(REQ_LOAD, 5'd5, 32'h55);
        req_valid = 3'b001;
        step();
        req_valid = 3'b111;
        rst_n     = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_regwrite", 32'(regwrite), 32'h0);
        check("midrst_busy", 32'(busy_1), 32'h0);
        check("midrst_ptr0", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b000;
        check("midrst_wreg", 32'(write_register), 32'd4);

`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward to read port 2 while reg 9 is marked busy.
        alloc_valid = 1'b1;
        alloc_reg   = 5'd9;
        step();
        alloc_valid     = 1'b0;
        read_register_1 = 5'd7;
        read_register_2 = 5'd9;
        set_req(REQ_LOAD, 5'd9, 32'hCAFE);
        req_valid = 3'b010;
        #1;
        check("fwd_valid_2", 32'(fwd_valid_2), 32'h1);
        check("fwd_data_2", fwd_data_2, 32'hCAFE);
        check("fwd_busy_2", 32'(busy_2), 32'h0);
        check("fwd_valid_1_off", 32'(fwd_valid_1), 32'h0);
        step();
        req_valid = 3'b000;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (regwrite / write_register / write_data) between NUM_REQ writeback requesters, e.g. ALU, load unit and multiply/divide.
- Arbitration is round-robin with a valid/ready handshake.
- Holds a 32-entry busy scoreboard: issue marks destinations busy, granted writes clear them. Decode uses the busy flags to stall reads of registers that are not yet written.
- Sits between the execute/memory stages and register_file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, write data width.
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_reg  in  NUM_REQ*REG_AW  destination register; requester i occupies bits [i*REG_AW +: REG_AW].
- req_data  in  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; the transfer occurs when req_valid[i] && req_ready[i].
- alloc_valid  in  1  issue stage reserves a destination register.
- alloc_reg  in  REG_AW  register to mark busy.
- read_register_1  in  REG_AW  decode source register 1.
- read_register_2  in  REG_AW  decode source register 2.
- busy_1  out  1  read_register_1 has a pending write.
- busy_2  out  1  read_register_2 has a pending write.
- regwrite  out  1  registered write enable to register_file.
- write_register  out  REG_AW  registered write address.
- write_data  out  DATA_W  registered write data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - regwrite=0, write_register=0, write_data=0.
  - Busy scoreboard is cleared to all zeros.
  - Round-robin pointer is set to 0.
  - req_ready is forced to 0 while rst_n=0.
  - Reset mid-operation discards the in-flight registered write: regwrite=0 on the next cycle.
- Arbitration (combinational):
  - Search starts at pointer p and wraps modulo NUM_REQ. The first i with req_valid[i]=1 is granted, and req_ready[i]=1.
  - At most one req_ready bit is high. req_ready is 0 when no request is valid.
  - A requester must hold valid, reg and data stable until it is granted.
- Pointer update: after a grant to requester g, p <= (g+1) mod NUM_REQ. With no grant, p holds its value.
- Write latency: a request granted in cycle N drives regwrite=1, write_register=req_reg[g] and write_data=req_data[g] during cycle N+1. With no grant, regwrite=0 in cycle N+1 and address/data hold their previous values.
- Throughput: one write per cycle. The port never back-pressures. Round-robin bounds starvation to NUM_REQ-1 cycles.
- Register $zero:
  - A granted request with req_reg=0 completes its handshake but produces regwrite=0.
  - alloc_reg=0 is ignored.
  - busy bit 0 is always 0.
- Scoreboard:
  - Each cycle, busy[alloc_reg] is set when alloc_valid=1.
  - busy[req_reg[g]] is cleared when a grant occurs. The clear takes effect at the same edge that loads the write registers.
  - Alloc and clear on the same register in the same cycle: alloc wins and the bit ends set. This covers a new producer issued as the old one writes back.
  - Alloc to a register that is already busy keeps it set. Only a single outstanding producer per register is tracked.
- Busy outputs:
  - busy_1 = busy[read_register_1] and busy_2 = busy[read_register_2], combinational from the registered scoreboard.
  - A write is not visible in busy_x until the edge after its grant.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- When defined, the block adds the outputs fwd_valid_1, fwd_valid_2 (1 bit) and fwd_data_1, fwd_data_2 (DATA_W).
  - fwd_valid_x=1 when the current cycle's granted request has req_reg[g] equal to read_register_x, and that register is non-zero.
  - fwd_data_x = req_data[g].
  - busy_x is suppressed to 0 in that case, so decode takes the forwarded value without stalling.
- When the macro is undefined, these ports do not exist and busy_x is purely scoreboard-based.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_AW=5, DATA_W=32, REG_ZERO=5'd0.
  - The requester index constants REQ_ALU=0, REQ_LOAD=1 and REQ_MULDIV=2.
- Sub-module rr_arbiter holds the round-robin pointer and the masked priority pick. It is parameterized by NUM_REQ and has inputs req and advance, and output grant one-hot. It is reusable for the memory port.
- The scoreboard and the output registers stay in the top module.

Test Plan:
- Reset then single write: req_valid=001, req_reg0=8, data0=32'hDEADBEEF → req_ready=001 in cycle N. Cycle N+1: regwrite=1, write_register=8, write_data=DEADBEEF.
- Round-robin fairness: req_valid=111 held for 6 cycles with p=0 → grants 001,010,100,001,010,100. The three requesters' data appears on write_data in that order, one cycle later each.
- Zero register: grant with req_reg=0, data=32'h1234 → req_ready=1, regwrite=0 next cycle. alloc_reg=0 leaves busy_1=0 when read_register_1=0.
- Scoreboard: alloc reg 9 → busy_1=1 (read_register_1=9) from the next cycle. A write to reg 9 granted in cycle N → busy_1=0 from cycle N+1.
- Simultaneous alloc and clear: alloc_reg=9 and granted write to reg 9 in the same cycle → busy[9] remains 1.
- Reset mid-operation: grant in cycle N with rst_n=0 at the same edge → regwrite=0 in N+1, all busy bits 0, next grant starts from requester 0.
  - With REGFILE_WRITE_BYPASS_EN: grant reg 9 with data 32'hCAFE while read_register_2=9 → fwd_valid_2=1, fwd_data_2=CAFE, busy_2=0 in the same cycle.
